// File: rtl/nv_async_req_arb_pkg.sv
// Shared types, constants and the round-robin picker for the async request arbiters.
package nv_async_req_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int SYNC_STAGES = 3;
   localparam int RR_MAX      = 16;

   // First set bit of elig at or above ptr, wrapping modulo n; returns ptr if none is set.
   function automatic logic [3:0] rr_find_first(input logic [RR_MAX-1:0] elig,
                                                input logic [3:0]        ptr,
                                                input int                n);
      logic [3:0] win;
      logic       found;
      int         idx;
      win   = ptr;
      found = 1'b0;
      for (int k = 0; k < RR_MAX; k++) begin
         idx = (int'(ptr) + k) % n;
         if (k < n && !found && elig[idx]) begin
            win   = idx[3:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/nv_sync3_clr_cell.sv
// One-bit, three-flop synchronizer with asynchronous active-low clear.
module nv_sync3_clr_cell
   import nv_async_req_arb_pkg::*;
(
   input  logic clk,
   input  logic clr_,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/nv_async_req_arb.sv
// Round-robin arbiter for NUM_REQ asynchronous 4-phase req/ack channels onto one service port.
// Optional grant timeout is compiled in with NV_ASYNC_ARB_TIMEOUT_EN.
module nv_async_req_arb
   import nv_async_req_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ID_W      = $clog2(NUM_REQ),
   parameter int TO_CYCLES = 255
) (
   input  logic               clk,
   input  logic               clr_,
   input  logic [NUM_REQ-1:0] req_async,
   output logic [NUM_REQ-1:0] ack,
   output logic               gnt_vld,
   output logic [ID_W-1:0]    gnt_id,
   input  logic               svc_done,
   output logic               err_to
);

   if (NUM_REQ < 2 || NUM_REQ > RR_MAX || TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_bad_cfg
      $error("nv_async_req_arb: NUM_REQ or TO_CYCLES out of range");
   end

   logic [NUM_REQ-1:0] req_s;
   logic [NUM_REQ-1:0] elig;
   logic [ID_W-1:0]    win_id;
   logic               timeout_hit;
   logic               done;

   arb_state_e         state_q, state_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
      nv_sync3_clr_cell u_sync (
         .clk  (clk),
         .clr_ (clr_),
         .d    (req_async[i]),
         .q    (req_s[i])
      );
   end

   // A channel still holding its ack has not finished its handshake and may not compete.
   assign elig   = req_s & ~ack_q;
   assign win_id = ID_W'(rr_find_first(16'(elig), 4'(ptr_q), NUM_REQ));
   assign done   = (state_q == GRANT) && (svc_done || timeout_hit);

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|elig) state_d = GRANT;
         GRANT:   if (done)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ack release is per channel and runs regardless of the arbiter state.
   always_comb begin
      gnt_id_d = gnt_id_q;
      ptr_d    = ptr_q;
      ack_d    = ack_q & req_s;
      if (state_q == IDLE && |elig) begin
         gnt_id_d = win_id;
      end
      if (done) begin
         ack_d[gnt_id_q] = 1'b1;
         ptr_d = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         gnt_id_q <= '0;
         ptr_q    <= '0;
         ack_q    <= '0;
      end else begin
         gnt_id_q <= gnt_id_d;
         ptr_q    <= ptr_d;
         ack_q    <= ack_d;
      end
   end

   assign gnt_vld = (state_q == GRANT);
   assign gnt_id  = gnt_id_q;
   assign ack     = ack_q;

`ifdef NV_ASYNC_ARB_TIMEOUT_EN
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        err_to_q, err_to_d;

   // Counter sits at zero while idle, so each grant starts counting from zero.
   assign timeout_hit = (to_cnt_q == 16'(TO_CYCLES - 1));

   always_comb begin
      to_cnt_d = (state_q == GRANT) ? to_cnt_q + 16'd1 : 16'd0;
      err_to_d = (state_q == GRANT) && timeout_hit && !svc_done;
   end

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         to_cnt_q <= '0;
         err_to_q <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         err_to_q <= err_to_d;
      end
   end

   assign err_to = err_to_q;
`else
   assign timeout_hit = 1'b0;
   assign err_to      = 1'b0;
`endif

endmodule

// File: tb/tb_nv_async_req_arb.sv
// Bench for nv_async_req_arb: directed scenarios plus random 4-phase traffic against a reference model.
// Build with NV_ASYNC_ARB_TIMEOUT_EN defined to cover the timeout feature (TO_CYCLES=10).
module tb_nv_async_req_arb;

   localparam int N  = 4;
   localparam int IW = 2;
`ifdef NV_ASYNC_ARB_TIMEOUT_EN
   localparam int TB_TO = 10;
`else
   localparam int TB_TO = 255;
`endif

   logic          clk = 1'b0;
   logic          clr_;
   logic [N-1:0]  req_async;
   logic [N-1:0]  ack;
   logic          gnt_vld;
   logic [IW-1:0] gnt_id;
   logic          svc_done;
   logic          err_to;

   int check_cnt = 0;
   int fail_cnt  = 0;

   always #5 clk = ~clk;

   nv_async_req_arb #(
      .NUM_REQ   (N),
      .ID_W      (IW),
      .TO_CYCLES (TB_TO)
   ) dut (
      .clk       (clk),
      .clr_      (clr_),
      .req_async (req_async),
      .ack       (ack),
      .gnt_vld   (gnt_vld),
      .gnt_id    (gnt_id),
      .svc_done  (svc_done),
      .err_to    (err_to)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: req_async values seen at each edge, current grant (-1 = none), pointer, acks.
   logic [N-1:0]  req_hist[$];
   int            m_gnt;
   int            m_ptr;
   int            m_age;
   logic [N-1:0]  m_ack;
   logic          m_err;
   logic [IW-1:0] got_q[$];
   logic [IW-1:0] exp_q[$];

   // The arbiter sees a request level three edges after it was presented.
   function automatic logic [N-1:0] model_req_s();
      if (req_hist.size() < 3) return '0;
      return req_hist[req_hist.size() - 3];
   endfunction

   task automatic model_reset();
      req_hist.delete();
      m_gnt = -1;
      m_ptr = 0;
      m_age = 0;
      m_ack = '0;
      m_err = 1'b0;
   endtask

   task automatic model_edge();
      logic [N-1:0] rs;
      logic [N-1:0] nack;
      logic         tmo;
      rs    = model_req_s();
      nack  = m_ack;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (m_ack[i] && !rs[i]) nack[i] = 1'b0;
      end
      if (m_gnt < 0) begin
         for (int k = 0; k < N; k++) begin
            if (m_gnt < 0 && rs[(m_ptr + k) % N] && !m_ack[(m_ptr + k) % N]) begin
               m_gnt = (m_ptr + k) % N;
               m_age = 0;
            end
         end
      end else begin
         tmo = 1'b0;
`ifdef NV_ASYNC_ARB_TIMEOUT_EN
         tmo = (m_age + 1 >= TB_TO);
`endif
         m_age++;
         if (svc_done || tmo) begin
            nack[m_gnt] = 1'b1;
            m_ptr = (m_gnt + 1) % N;
            m_err = tmo && !svc_done;
            m_gnt = -1;
         end
      end
      m_ack = nack;
      req_hist.push_back(req_async);
      if (req_hist.size() > 8) void'(req_hist.pop_front());
   endtask

   task automatic compare_all();
      check("gnt_vld", gnt_vld, m_gnt >= 0);
      if (m_gnt >= 0) check("gnt_id", gnt_id, m_gnt);
      check("ack", ack, m_ack);
      check("err_to", err_to, m_err);
   endtask

   // One clock: the model follows the edge, outputs are compared on the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset(input string tag);
      #2 clr_ = 1'b0;
      #1;
      check({tag, "_gnt_vld"}, gnt_vld, 0);
      check({tag, "_gnt_id"}, gnt_id, 0);
      check({tag, "_ack"}, ack, 0);
      check({tag, "_err_to"}, err_to, 0);
      model_reset();
      @(negedge clk);
      clr_ = 1'b1;
   endtask

   task automatic wait_grant(input string tag);
      int cyc;
      cyc = 0;
      while (!gnt_vld && cyc < 20) begin
         step();
         cyc++;
      end
      check({tag, "_grant_seen"}, gnt_vld, 1);
   endtask

   // Serve n grants, pulsing svc_done dly cycles after each grant appears.
   task automatic serve(input int n, input int dly, input string tag);
      int   served;
      int   age;
      int   cyc;
      logic prev;
      served = 0;
      age    = 0;
      cyc    = 0;
      prev   = 1'b0;
      while (served < n && cyc < 300) begin
         step();
         cyc++;
         if (svc_done) served++;
         svc_done = 1'b0;
         if (gnt_vld && !prev) begin
            got_q.push_back(gnt_id);
            age = 0;
         end else if (gnt_vld) begin
            age++;
         end
         prev = gnt_vld;
         if (gnt_vld && age == dly && served < n) svc_done = 1'b1;
      end
      svc_done = 1'b0;
      check({tag, "_served"}, served, n);
   endtask

   task automatic check_order(input string tag);
      check({tag, "_order_len"}, got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         check({tag, "_order"}, got_q[k], exp_q[k]);
      end
   endtask

   initial begin
      int held;
      clr_      = 1'b0;
      req_async = '0;
      svc_done  = 1'b0;
      @(negedge clk);
      do_reset("rst0");

      // Single request on channel 2: four-edge grant latency, ack on service, ack release.
      req_async[2] = 1'b1;
      repeat (3) begin
         step();
         check("t1_no_gnt_yet", gnt_vld, 0);
      end
      step();
      check("t1_gnt_vld", gnt_vld, 1);
      check("t1_gnt_id", gnt_id, 2);
      step();
      step();
      svc_done = 1'b1;
      step();
      svc_done = 1'b0;
      check("t1_ack", ack, 4'b0100);
      check("t1_gnt_drop", gnt_vld, 0);
      req_async[2] = 1'b0;
      repeat (3) begin
         step();
         check("t1_ack_held", ack[2], 1);
      end
      step();
      check("t1_ack_released", ack[2], 0);

      // All four from reset: order 0..3 twice, pointer wraps back to 0.
      do_reset("rst1");
      req_async = '1;
      got_q.delete();
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
      serve(4, 2, "t2a");
      check_order("t2a");
      req_async = '0;
      repeat (6) step();
      check("t2_acks_clear", ack, 0);
      req_async = '1;
      got_q.delete();
      serve(4, 2, "t2b");
      check_order("t2b");
      req_async = '0;
      repeat (6) step();

      // svc_done while idle with nothing requesting.
      repeat (5) begin
         svc_done = 1'b1;
         step();
         svc_done = 1'b0;
         step();
      end
      check("t3_idle_gnt", gnt_vld, 0);
      check("t3_idle_ack", ack, 0);

      // Requester 1 withdraws during its grant.
      req_async[1] = 1'b1;
      wait_grant("t4");
      check("t4_gnt_id", gnt_id, 1);
      req_async[1] = 1'b0;
      repeat (6) begin
         step();
         check("t4_held", gnt_vld, 1);
      end
      svc_done = 1'b1;
      step();
      svc_done = 1'b0;
      check("t4_ack_up", ack[1], 1);
      step();
      check("t4_ack_down", ack[1], 0);

      // Reset while granting channel 1 with ack[0] high; channel 0 regrants after release.
      do_reset("rst2");
      req_async = 4'b0011;
      got_q.delete();
      serve(1, 1, "t5a");
      wait_grant("t5b");
      check("t5_gnt_id1", gnt_id, 1);
      check("t5_ack0", ack[0], 1);
      do_reset("t5_rst");
      repeat (3) begin
         step();
         check("t5_no_gnt_yet", gnt_vld, 0);
      end
      step();
      check("t5_regrant_vld", gnt_vld, 1);
      check("t5_regrant_id", gnt_id, 0);

`ifdef NV_ASYNC_ARB_TIMEOUT_EN
      // Timeout aborts the grant; svc_done on the timeout cycle wins.
      do_reset("rst3");
      req_async = 4'b0001;
      wait_grant("t6a");
      repeat (TB_TO - 1) begin
         step();
         check("t6_no_err_yet", err_to, 0);
      end
      step();
      check("t6_err_to", err_to, 1);
      check("t6_ack0", ack[0], 1);
      check("t6_gnt_drop", gnt_vld, 0);
      req_async = 4'b0000;
      repeat (6) step();
      req_async = 4'b0010;
      wait_grant("t6b");
      repeat (TB_TO - 1) step();
      svc_done = 1'b1;
      step();
      svc_done = 1'b0;
      check("t6_svc_wins_err", err_to, 0);
      check("t6_svc_wins_ack", ack[1], 1);
      req_async = 4'b0000;
      repeat (6) step();
`else
      // Without the timeout a grant waits indefinitely.
      do_reset("rst3");
      req_async = 4'b0001;
      wait_grant("t6");
      held = 0;
      repeat (1000) begin
         step();
         if (gnt_vld) held++;
      end
      check("t6_held_cycles", held, 1000);
      svc_done = 1'b1;
      step();
      svc_done = 1'b0;
      req_async = 4'b0000;
      repeat (6) step();
`endif

      // Random 4-phase traffic, including occasional early withdrawals.
      do_reset("rst4");
      req_async = '0;
      repeat (1500) begin
         for (int i = 0; i < N; i++) begin
            if (!req_async[i] && !m_ack[i] && $urandom_range(0, 3) == 0) req_async[i] = 1'b1;
            else if (req_async[i] && m_ack[i] && $urandom_range(0, 2) == 0) req_async[i] = 1'b0;
            else if (req_async[i] && !m_ack[i] && $urandom_range(0, 60) == 0) req_async[i] = 1'b0;
         end
         svc_done = ($urandom_range(0, 2) == 0);
         step();
      end
      svc_done  = 1'b0;
      req_async = '0;
      repeat (8) step();

      $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
      $finish;
   end

endmodule
